// File: rtl/ones_word_gen.sv
// Word generator: turns a bit count N into a WIDTH-bit word holding exactly
// min(N, WIDTH) ones at LFSR-chosen positions. One bit is placed per clock.

module ones_word_gen_lfsr #(
  parameter int IW = 3
) (
  input  logic          clk_i,
  input  logic          arst_n_i,
  input  logic          load_i,
  input  logic [15:0]   seed_i,
  output logic [IW-1:0] low_o
);
  logic [15:0] q;
  logic        fb;

  // Fibonacci taps 16,14,13,11
  assign fb    = q[15] ^ q[13] ^ q[12] ^ q[10];
  assign low_o = q[IW-1:0];

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i)   q <= 16'hACE1;
    else if (load_i) q <= (seed_i == 16'h0000) ? 16'hACE1 : seed_i;
    else             q <= {q[14:0], fb};
  end
endmodule

module ones_word_gen #(
  parameter  int WIDTH = 8,
  localparam int CW    = $clog2(WIDTH) + 2
) (
  input  logic             clk_i,
  input  logic             arst_n_i,
  input  logic             data_val_i,
  input  logic [CW-1:0]    data_i,
  output logic             data_ready_o,
  input  logic             seed_load_i,
  input  logic [15:0]      seed_i,
  output logic             data_val_o,
  output logic [WIDTH-1:0] data_o,
  output logic             err_o
);
  localparam int            IW      = $clog2(WIDTH);
  localparam logic [CW-1:0] WIDTH_C = CW'(WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_FILL, S_OUT} state_t;

  state_t           state_q, state_d;
  logic             ready_q;
  logic             val_q;
  logic             err_q;
  logic             err_lat;
  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] word_q;
  logic [CW-1:0]    rem_q;

  logic             accept;
  logic             over;
  logic [CW-1:0]    n_eff;
  logic [IW-1:0]    lfsr_low;
  logic [IW-1:0]    idx;
  logic [WIDTH-1:0] set_mask;

  assign accept       = data_val_i & ready_q;
  assign over         = (data_i > WIDTH_C);
  assign n_eff        = over ? WIDTH_C : data_i;
  assign data_ready_o = ready_q;
  assign data_val_o   = val_q;
  assign data_o       = data_q;
  assign err_o        = err_q;

  ones_word_gen_lfsr #(.IW(IW)) u_lfsr (
    .clk_i    (clk_i),
    .arst_n_i (arst_n_i),
    .load_i   (seed_load_i && (state_q == S_IDLE)),
    .seed_i   (seed_i),
    .low_o    (lfsr_low)
  );

  // Fold out-of-range indices back into the word for non power-of-two widths
  assign idx = (int'(lfsr_low) >= WIDTH) ? IW'(int'(lfsr_low) - WIDTH) : lfsr_low;

  // First clear bit at or above idx, wrapping; exactly one bit of set_mask is set
  always_comb begin : pick
    logic          found;
    int            p;
    logic [IW-1:0] pos;
    set_mask = '0;
    found    = 1'b0;
    p        = 0;
    pos      = '0;
    for (int k = 0; k < WIDTH; k++) begin
      p = int'(idx) + k;
      if (p >= WIDTH) p = p - WIDTH;
      pos = IW'(p);
      if (!found && !word_q[pos]) begin
        set_mask[pos] = 1'b1;
        found         = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept) state_d = (n_eff == '0) ? S_OUT : S_FILL;
      S_FILL:  if (rem_q == CW'(1)) state_d = S_OUT;
      S_OUT:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      state_q <= S_IDLE;
      ready_q <= 1'b1;
      val_q   <= 1'b0;
      err_q   <= 1'b0;
      err_lat <= 1'b0;
      data_q  <= '0;
      word_q  <= '0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      // Ready returns one cycle after the output pulse, and drops on accept
      ready_q <= (state_q == S_IDLE) && !accept;
      val_q   <= (state_q == S_OUT);
      err_q   <= (state_q == S_OUT) && err_lat;
      case (state_q)
        S_IDLE: if (accept) begin
          rem_q   <= n_eff;
          err_lat <= over;
          word_q  <= '0;
        end
        S_FILL: begin
          word_q <= word_q | set_mask;
          rem_q  <= rem_q - CW'(1);
        end
        S_OUT: begin
          data_q <= word_q;
          word_q <= '0;
        end
        default: ;
      endcase
    end
  end
endmodule
